apb_mem_arbiter: RTL
====================

APB_MEM_ARBITER -- requirements
Module: apb_mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, max ACCESS cycles with PReady low before abort (range 1..255).
REQ-002 SHALL have port PClk  input  1  rising-edge clock.
REQ-003 SHALL have port PResetn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports rN_req  input  1  transfer request from requester N (N=0,1); held high until rN_done.
REQ-005 SHALL have ports rN_write  input  1  1=write, 0=read; stable while rN_req high.
REQ-006 SHALL have ports rN_addr  input  16  byte address; stable while rN_req high.
REQ-007 SHALL have ports rN_wdata  input  8  write data; stable while rN_req high.
REQ-008 SHALL have ports rN_done  output  1  one-cycle completion pulse.
REQ-009 SHALL have ports rN_err  output  1  valid with rN_done; 1 = timeout abort.
REQ-010 SHALL have ports rN_rdata  output  8  last read data returned to requester N.
REQ-011 SHALL have port PAddr  output  16  APB address.
REQ-012 SHALL have port PSelx  output  1  APB select.
REQ-013 SHALL have port PEnable  output  1  APB enable.
REQ-014 SHALL have port PWrite  output  1  APB direction.
REQ-015 SHALL have port PWData  output  8  APB write data.
REQ-016 SHALL have port PReady  input  1  APB slave ready.
REQ-017 SHALL have port PRData  input  8  APB read data.

Function
REQ-018 SHALL implement FSM IDLE, SETUP, ACCESS, DONE; APB outputs decoded from registered state and latched transfer registers only (no combinational path from rN_* to APB outputs).
REQ-019 IDLE: if any rN_req high -> SETUP, latching granted requester's index, write, addr, wdata; else stay IDLE.
REQ-020 Arbitration: single requester -> grant it; both -> grant requester not granted last (round-robin); pointer updates on each grant.
REQ-021 SETUP (exactly 1 cycle): PSelx=1, PEnable=0, PAddr/PWrite/PWData = latched values -> ACCESS.
REQ-022 ACCESS: PSelx=1, PEnable=1, same latched values; PReady=1 -> DONE; PReady=0 -> stay, wait counter +1.
REQ-023 Wait counter cleared on SETUP entry; when counter = TIMEOUT and PReady=0 -> DONE with abort flag set.
REQ-024 On ACCESS exit with PReady=1 and read: rN_rdata of granted requester <= PRData; other requester's rdata unchanged; writes and aborts leave rdata unchanged.
REQ-025 DONE (exactly 1 cycle): rN_done=1 for granted requester only, rN_err = abort flag; PSelx=0, PEnable=0 -> IDLE.
REQ-026 IDLE and DONE: PSelx=0, PEnable=0, PAddr=0, PWrite=0, PWData=0.
REQ-027 Latency, zero-wait slave: req high in IDLE cycle 0 -> SETUP cycle 1 -> ACCESS cycle 2 -> done cycle 3; max throughput one transfer per 4 cycles.
REQ-028 rN_req still high in cycle after rN_done SHALL be treated as a new request.
REQ-029 rN_req dropped mid-transfer SHALL NOT abort; transfer completes and rN_done still pulses.
REQ-030 rN_done never asserted for both requesters in the same cycle; PSelx never high in IDLE/DONE.

Reset
REQ-031 PResetn low SHALL asynchronously force IDLE, all outputs 0, rN_rdata=0, wait counter 0, round-robin pointer so r0 wins first tie.
REQ-032 Reset mid-transfer SHALL drop the transfer with no rN_done; first post-reset request restarts from SETUP.

Verification
REQ-033 r0 write addr 0x1234 data 0xA5, PReady=1 in first ACCESS -> SETUP/ACCESS carry 0x1234/0xA5/PWrite=1, r0_done=1 r0_err=0 in cycle 3.
REQ-034 r1 read addr 0x00FF, PReady low 2 ACCESS cycles then high with PRData=0x3C -> r1_rdata=0x3C, r1_done in cycle 5, r0_rdata unchanged.
REQ-035 r0,r1 both requesting continuously after reset -> grants r0,r1,r0,r1, each done 4 cycles apart.
REQ-036 PReady held 0, TIMEOUT=15 -> r0_done=1 r0_err=1 after 16 ACCESS cycles, rdata unchanged, PSelx=0 next cycle.
REQ-037 PResetn low during ACCESS -> APB outputs 0 immediately, no done pulse; next request completes normally with r0 winning tie.

Source files
------------

// File: rtl/apb_mem_arbiter.sv
// Two-requester round-robin arbiter driving a single APB master port.
// Each grant runs one IDLE->SETUP->ACCESS->DONE transfer with a PReady timeout abort.
module apb_mem_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        PClk,
  input  logic        PResetn,
  input  logic        r0_req,
  input  logic        r0_write,
  input  logic [15:0] r0_addr,
  input  logic [7:0]  r0_wdata,
  output logic        r0_done,
  output logic        r0_err,
  output logic [7:0]  r0_rdata,
  input  logic        r1_req,
  input  logic        r1_write,
  input  logic [15:0] r1_addr,
  input  logic [7:0]  r1_wdata,
  output logic        r1_done,
  output logic        r1_err,
  output logic [7:0]  r1_rdata,
  output logic [15:0] PAddr,
  output logic        PSelx,
  output logic        PEnable,
  output logic        PWrite,
  output logic [7:0]  PWData,
  input  logic        PReady,
  input  logic [7:0]  PRData
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  state_t      state_q, state_d;
  logic        gnt_q, gnt_d;
  logic        last_q, last_d;
  logic        write_q, write_d;
  logic        abort_q, abort_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  wait_q, wait_d;
  logic [7:0]  rdata0_q, rdata0_d;
  logic [7:0]  rdata1_q, rdata1_d;
  logic        sel;
  logic        active;

  // last_q resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge PClk or negedge PResetn) begin
    if (!PResetn) begin
      state_q  <= IDLE;
      gnt_q    <= 1'b0;
      last_q   <= 1'b1;
      write_q  <= 1'b0;
      abort_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wait_q   <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      write_q  <= write_d;
      abort_q  <= abort_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wait_q   <= wait_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    write_d  = write_q;
    abort_d  = abort_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wait_d   = wait_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    sel      = (r0_req && r1_req) ? ~last_q : r1_req;

    case (state_q)
      IDLE: begin
        if (r0_req || r1_req) begin
          state_d = SETUP;
          gnt_d   = sel;
          last_d  = sel;
          write_d = sel ? r1_write : r0_write;
          addr_d  = sel ? r1_addr  : r0_addr;
          wdata_d = sel ? r1_wdata : r0_wdata;
          wait_d  = '0;
          abort_d = 1'b0;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (PReady) begin
          state_d = DONE;
          if (!write_q) begin
            if (gnt_q) rdata1_d = PRData;
            else       rdata0_d = PRData;
          end
        end else if (wait_q == TMO) begin
          state_d = DONE;
          abort_d = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // APB outputs come only from state and latched transfer registers.
  assign active   = (state_q == SETUP) || (state_q == ACCESS);
  assign PSelx    = active;
  assign PEnable  = (state_q == ACCESS);
  assign PAddr    = active ? addr_q  : '0;
  assign PWrite   = active ? write_q : 1'b0;
  assign PWData   = active ? wdata_q : '0;

  assign r0_done  = (state_q == DONE) && !gnt_q;
  assign r1_done  = (state_q == DONE) &&  gnt_q;
  assign r0_err   = r0_done && abort_q;
  assign r1_err   = r1_done && abort_q;
  assign r0_rdata = rdata0_q;
  assign r1_rdata = rdata1_q;

endmodule
